// File: rtl/dct_2d_row_col_ctrl.sv
// Row/column sequencer for the 2-D DCT: loads 16 row-DCT results into a transpose buffer, then streams out columns.
// Optional DCT_CTRL_STALL_CNT_EN adds a saturating stall_cnt output counting col_valid&!col_ready cycles.

module dct_tbuf_row #(
   parameter int BW = 11
) (
   input  logic             clk,
   input  logic             we,
   input  logic [16*BW-1:0] din,
   input  logic [3:0]       sel,
   output logic [BW-1:0]    dout
);
   logic [BW-1:0] q [16];

   // Storage only; contents are meaningless until a full block has been written.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < 16; k++) q[k] <= din[(15-k)*BW +: BW];
      end
   end

   assign dout = q[sel];
endmodule

module dct_2d_row_col_ctrl #(
   parameter int PIX_W = 8,
   parameter int BW    = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pix_valid,
   output logic                pix_ready,
   input  logic [16*PIX_W-1:0] pix_data,
   output logic [16*PIX_W-1:0] row_x_out,
   input  logic [16*BW-1:0]    row_X_in,
   output logic                col_valid,
   input  logic                col_ready,
   output logic [16*BW-1:0]    col_data,
   output logic [3:0]          col_idx,
   output logic                blk_done,
   output logic                busy
`ifdef DCT_CTRL_STALL_CNT_EN
  ,output logic [15:0]         stall_cnt
`endif
);
   typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

   state_t     state;
   logic [3:0] row_cnt;
   logic [3:0] col_cnt;
   logic       pix_acc;
   logic       col_hs;

   assign row_x_out = pix_data;
   assign pix_acc   = pix_valid & pix_ready;
   assign col_hs    = col_valid & col_ready;
   assign col_idx   = col_cnt;
   assign busy      = (row_cnt != 4'd0) | (state == DRAIN);

   // Row DCT is combinational, so its result is captured in the accept cycle.
   for (genvar r = 0; r < 16; r++) begin : g_row
      dct_tbuf_row #(.BW(BW)) u_row (
         .clk  (clk),
         .we   (pix_acc && (row_cnt == 4'(r))),
         .din  (row_X_in),
         .sel  (col_cnt),
         .dout (col_data[(15-r)*BW +: BW])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         row_cnt   <= 4'd0;
         col_cnt   <= 4'd0;
         blk_done  <= 1'b0;
         pix_ready <= 1'b1;
         col_valid <= 1'b0;
      end else begin
         blk_done <= 1'b0;
         case (state)
            LOAD: begin
               if (pix_acc) begin
                  row_cnt <= row_cnt + 4'd1;
                  if (row_cnt == 4'd15) begin
                     state     <= DRAIN;
                     pix_ready <= 1'b0;
                     col_valid <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (col_hs) begin
                  col_cnt <= col_cnt + 4'd1;
                  if (col_cnt == 4'd15) begin
                     state     <= LOAD;
                     pix_ready <= 1'b1;
                     col_valid <= 1'b0;
                     blk_done  <= 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

`ifdef DCT_CTRL_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= 16'd0;
      else if (col_valid && !col_ready && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_dct_2d_row_col_ctrl.sv
// Bench for dct_2d_row_col_ctrl with a behavioural orthonormal 16-point row DCT between row_x_out and row_X_in.
// Column results are scoreboarded; optional DCT_CTRL_STALL_CNT_EN checks are compiled in when defined.

module tb_dct_2d_row_col_ctrl;
   localparam int PIX_W = 8;
   localparam int BW    = 11;
   localparam int CW    = 16*BW;
   localparam int XW    = 16*PIX_W;
   localparam real PI   = 3.14159265358979323846;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [XW-1:0] pix_data = '0;
   logic [XW-1:0] row_x_out;
   logic [CW-1:0] row_X_in;
   logic          col_valid;
   logic          col_ready = 1'b1;
   logic [CW-1:0] col_data;
   logic [3:0]    col_idx;
   logic          blk_done;
   logic          busy;
`ifdef DCT_CTRL_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   dct_2d_row_col_ctrl #(.PIX_W(PIX_W), .BW(BW)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .row_x_out (row_x_out),
      .row_X_in  (row_X_in),
      .col_valid (col_valid),
      .col_ready (col_ready),
      .col_data  (col_data),
      .col_idx   (col_idx),
      .blk_done  (blk_done),
      .busy      (busy)
`ifdef DCT_CTRL_STALL_CNT_EN
     ,.stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] row_dct(input logic [XW-1:0] x);
      logic [CW-1:0] o;
      real s;
      int v;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         s = 0.0;
         for (int n = 0; n < 16; n++)
            s += real'(int'(x[(15-n)*PIX_W +: PIX_W])) * $cos(PI * real'(2*n+1) * real'(k) / 32.0);
         s = s * ((k == 0) ? 0.25 : 0.35355339059327376);
         v = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
         if (v > 1023) v = 1023;
         if (v < -1024) v = -1024;
         o[(15-k)*BW +: BW] = v[BW-1:0];
      end
      return o;
   endfunction

   assign row_X_in = row_dct(row_x_out);

   typedef struct {
      logic [CW-1:0] data;
      logic [3:0]    idx;
   } exp_t;

   typedef struct {
      logic [PIX_W-1:0] fill;
      logic [BW-1:0]    exp_dc;
   } vec_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            n_vec = 0;
   int            n_err = 0;
   int            blk_cnt = 0;
   int            drain_cyc = 0;
   int            cyc = 0;
   int            acc_cyc [32];
   logic [XW-1:0] rows_mem [32];

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard side: every column handshake pops one expected column.
   always @(negedge clk) begin
      if (pix_ready === 1'b0) drain_cyc++;
      if (blk_done === 1'b1) begin
         blk_cnt++;
         chk("blk_done_pix_ready", CW'(pix_ready), CW'(1));
         chk("blk_done_col_valid", CW'(col_valid), CW'(0));
      end
      if (col_valid === 1'b1 && col_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_column: got idx %0d want none", col_idx);
         end else begin
            mon_e = sb.pop_front();
            chk("col_idx", CW'(col_idx), CW'(mon_e.idx));
            chk("col_data", col_data, mon_e.data);
         end
      end
   end

   task automatic push_block(input int base);
      logic [CW-1:0] coef [16];
      exp_t e;
      for (int r = 0; r < 16; r++) coef[r] = row_dct(rows_mem[base+r]);
      for (int c = 0; c < 16; c++) begin
         e.idx  = 4'(c);
         e.data = '0;
         for (int r = 0; r < 16; r++) e.data[(15-r)*BW +: BW] = coef[r][(15-c)*BW +: BW];
         sb.push_back(e);
      end
   endtask

   task automatic push_const(input logic [BW-1:0] dc);
      exp_t e;
      for (int c = 0; c < 16; c++) begin
         e.idx  = 4'(c);
         e.data = '0;
         if (c == 0) for (int r = 0; r < 16; r++) e.data[(15-r)*BW +: BW] = dc;
         sb.push_back(e);
      end
   endtask

   task automatic rand_rows(input int base, input int n);
      for (int r = 0; r < n; r++)
         for (int p = 0; p < 16; p++) rows_mem[base+r][p*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
   endtask

   task automatic drive_rows(input int base, input int n, input bit toggle);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
         pix_data  = rows_mem[base+i];
         pix_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pix_valid && pix_ready) begin
            acc_cyc[i] = cyc;
            i++;
         end
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
      chk("rows_accepted", CW'(i), CW'(n));
   endtask

   task automatic wait_done(input int target);
      int g = 0;
      while (blk_cnt < target && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      @(posedge clk); #1;
      chk("blk_done_count", CW'(blk_cnt), CW'(target));
      chk("busy_after_block", CW'(busy), CW'(0));
      chk("sb_empty", CW'(sb.size()), CW'(0));
   endtask

   vec_t vecs [4];
   int   start;

   initial begin
      vecs[0] = '{fill: 8'h80, exp_dc: 11'd512};
      vecs[1] = '{fill: 8'h00, exp_dc: 11'd0};
      vecs[2] = '{fill: 8'hFF, exp_dc: 11'd1020};
      vecs[3] = '{fill: 8'h01, exp_dc: 11'd4};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_pix_ready", CW'(pix_ready), CW'(1));
      chk("rst_col_valid", CW'(col_valid), CW'(0));
      chk("rst_col_idx", CW'(col_idx), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_blk_done", CW'(blk_done), CW'(0));

      // Uniform blocks: only column 0 carries energy, equal to 4*pixel.
      for (int v = 0; v < 4; v++) begin
         for (int r = 0; r < 16; r++) rows_mem[r] = {16{vecs[v].fill}};
         start = blk_cnt;
         drain_cyc = 0;
         push_const(vecs[v].exp_dc);
         drive_rows(0, 16, 1'b0);
         wait_done(start + 1);
         chk("flat_drain_cycles", CW'(drain_cyc), CW'(16));
      end

      // Random block with a bursty source.
      rand_rows(0, 16);
      start = blk_cnt;
      drain_cyc = 0;
      push_block(0);
      drive_rows(0, 16, 1'b1);
      wait_done(start + 1);
      chk("rand_drain_cycles", CW'(drain_cyc), CW'(16));

      // Reset after a partial block.
      rand_rows(0, 7);
      drive_rows(0, 7, 1'b1);
      chk("partial_busy", CW'(busy), CW'(1));
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("midrst_busy", CW'(busy), CW'(0));
      chk("midrst_pix_ready", CW'(pix_ready), CW'(1));
      chk("midrst_col_valid", CW'(col_valid), CW'(0));
      rand_rows(0, 16);
      start = blk_cnt;
      push_block(0);
      drive_rows(0, 16, 1'b0);
      chk("no_early_blk_done", CW'(blk_cnt), CW'(start));
      chk("drain_after_load", CW'(col_valid), CW'(1));
      wait_done(start + 1);

      // Downstream stall on column 3.
      rand_rows(0, 16);
      start = blk_cnt;
      push_block(0);
      drive_rows(0, 16, 1'b0);
      for (int g = 0; g < 40 && !(col_valid && col_idx == 4'd3); g++) begin
         @(posedge clk); #1;
      end
      col_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); #1;
         chk("stall_col_valid", CW'(col_valid), CW'(1));
         chk("stall_col_idx", CW'(col_idx), CW'(3));
         chk("stall_col_data", col_data, (sb.size() > 0) ? sb[0].data : '0);
      end
      col_ready = 1'b1;
      @(posedge clk); #1;
      chk("resume_col_idx", CW'(col_idx), CW'(4));
      wait_done(start + 1);
`ifdef DCT_CTRL_STALL_CNT_EN
      chk("stall_cnt_block_end", CW'(stall_cnt), CW'(5));
`endif

      // Back-to-back blocks with source and sink always ready.
      rand_rows(0, 32);
      start = blk_cnt;
      push_block(0);
      push_block(16);
      drive_rows(0, 32, 1'b0);
      chk("block_period", CW'(acc_cyc[16] - acc_cyc[0]), CW'(32));
      wait_done(start + 2);
`ifdef DCT_CTRL_STALL_CNT_EN
      chk("stall_cnt_hold", CW'(stall_cnt), CW'(5));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
